// File: rtl/ysyx_24080014_wb_ctrl.sv
// Write-back controller: picks the rd source, waits for LSU load data, drives the RF write port and commit pulse.
// Optional load-timeout watchdog is enabled by defining WB_TIMEOUT_EN.
module ysyx_24080014_wb_ctrl #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_rd_ctl,
  input  logic        in_rd_wen,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_csr_data,
  input  logic        ld_rvalid,
  input  logic [31:0] ld_rdata,
  output logic        ld_rready,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        commit,
  output logic [31:0] commit_pc,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, WRITE} state_e;

  localparam logic [2:0] CTL_PC     = 3'b000;
  localparam logic [2:0] CTL_PC_ADD = 3'b001;
  localparam logic [2:0] CTL_ALU    = 3'b010;
  localparam logic [2:0] CTL_IMM    = 3'b011;
  localparam logic [2:0] CTL_LOAD   = 3'b100;
  localparam logic [2:0] CTL_RS1    = 3'b101;
  localparam logic [2:0] CTL_CSR    = 3'b110;
  localparam logic [2:0] CTL_NONE   = 3'b111;

  state_e      state_q, state_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        rd_wen_q, rd_wen_d;
  logic [2:0]  rd_ctl_q, rd_ctl_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] wdata_q, wdata_d;
  logic        kill_q, kill_d;    // suppresses the RF write of a timed-out load
  logic        terr_q, terr_d;
  logic        accept;
  logic [31:0] src_mux;

  assign in_ready = (state_q != LOAD_WAIT) && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    src_mux = 32'h0;
    case (in_rd_ctl)
      CTL_PC:     src_mux = in_pc;
      CTL_PC_ADD: src_mux = in_pc + 32'd4;
      CTL_ALU:    src_mux = in_alu_out;
      CTL_IMM:    src_mux = in_imm;
      CTL_RS1:    src_mux = in_rs1_data;
      CTL_CSR:    src_mux = in_csr_data;
      default:    src_mux = 32'h0;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_wen_d  = rd_wen_q;
    rd_ctl_d  = rd_ctl_q;
    pc_d      = pc_q;
    wdata_d   = wdata_q;
    kill_d    = kill_q;
    terr_d    = terr_q;
`ifdef WB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          rd_addr_d = in_rd_addr;
          rd_wen_d  = in_rd_wen;
          rd_ctl_d  = in_rd_ctl;
          pc_d      = in_pc;
          wdata_d   = src_mux;
          kill_d    = 1'b0;
          state_d   = (in_rd_ctl == CTL_LOAD) ? LOAD_WAIT : WRITE;
`ifdef WB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_WAIT: begin
        if (ld_rvalid) begin
          wdata_d = ld_rdata;
          state_d = WRITE;
        end
`ifdef WB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          kill_d  = 1'b1;
          terr_d  = 1'b1;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_wen_q  <= 1'b0;
      rd_ctl_q  <= '0;
      pc_q      <= '0;
      wdata_q   <= '0;
      kill_q    <= 1'b0;
      terr_q    <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_wen_q  <= rd_wen_d;
      rd_ctl_q  <= rd_ctl_d;
      pc_q      <= pc_d;
      wdata_q   <= wdata_d;
      kill_q    <= kill_d;
      terr_q    <= terr_d;
`ifdef WB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign ld_rready   = (state_q == LOAD_WAIT);
  assign busy        = (state_q != IDLE);
  assign commit      = (state_q == WRITE);
  assign rf_wen      = commit && rd_wen_q && (rd_addr_q != 5'd0) && (rd_ctl_q != CTL_NONE) && !kill_q;
  assign rf_waddr    = rd_addr_q;
  assign rf_wdata    = wdata_q;
  assign commit_pc   = pc_q;
`ifdef WB_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
